// File: rtl/dvp_tx_pkg.sv
// Shared DVP definitions: frame-state encoding and default video timing.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } dvp_state_e;

  localparam int DVP_H_ACTIVE  = 640;
  localparam int DVP_V_ACTIVE  = 480;
  localparam int DVP_H_BLANK   = 144;
  localparam int DVP_VS_LINES  = 3;
  localparam int DVP_VBP_LINES = 17;
  localparam int DVP_VFP_LINES = 10;

endpackage

// File: rtl/dvp_tx_timing.sv
// DVP raster generator: pclk phase, pclk/line counters and frame state.
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int VS_LINES  = DVP_VS_LINES,
  parameter int VBP_LINES = DVP_VBP_LINES,
  parameter int VFP_LINES = DVP_VFP_LINES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic pclk_o,
  output logic upd_o,
  output logic href_next_o,
  output logic byte_hi_next_o,
  output logic frame_start_o,
  output logic href_o,
  output logic vsync_o,
  output logic frame_done_o
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
  localparam int HW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_HREF = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] V_BP0  = VW'(VS_LINES);
  localparam logic [VW-1:0] V_ACT0 = VW'(VS_LINES + VBP_LINES);
  localparam logic [VW-1:0] V_FP0  = VW'(VS_LINES + VBP_LINES + V_ACTIVE);

  dvp_state_e      state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            pclk_q, href_q, href_d, vsync_q, vsync_d, fdone_q;
  logic            last_pos;

  function automatic dvp_state_e state_of(input logic [VW-1:0] v);
    dvp_state_e s;
    if (v < V_BP0)       s = ST_VSYNC;
    else if (v < V_ACT0) s = ST_VBP;
    else if (v < V_FP0)  s = ST_ACTIVE;
    else                 s = ST_VFP;
    return s;
  endfunction

  // h/v/state describe the pclk period currently on the wire; *_d is the next one.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (state_q == ST_IDLE) begin
      if (enable_i) state_d = ST_VSYNC;
    end else if (h_q != H_LAST) begin
      h_d = h_q + HW'(1);
    end else if (v_q != V_LAST) begin
      h_d     = '0;
      v_d     = v_q + VW'(1);
      state_d = state_of(v_d);
    end else begin
      h_d     = '0;
      v_d     = '0;
      state_d = enable_i ? ST_VSYNC : ST_IDLE;
    end
    href_d  = (state_d == ST_ACTIVE) && (h_d < H_HREF);
    vsync_d = (state_d == ST_VSYNC);
  end

  assign last_pos = (state_q != ST_IDLE) && (h_q == H_LAST) && (v_q == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q  <= 1'b0;
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      pclk_q  <= ~pclk_q;
      fdone_q <= ~pclk_q & last_pos;
      if (pclk_q) begin
        state_q <= state_d;
        h_q     <= h_d;
        v_q     <= v_d;
        href_q  <= href_d;
        vsync_q <= vsync_d;
      end
    end
  end

  assign pclk_o         = pclk_q;
  assign upd_o          = pclk_q;
  assign href_next_o    = href_d;
  assign byte_hi_next_o = ~h_d[0];
  assign frame_start_o  = pclk_q && (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
  assign href_o         = href_q;
  assign vsync_o        = vsync_q;
  assign frame_done_o   = fdone_q;

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter top: pixel handshake, byte serialisation and underrun flag.
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int VS_LINES  = DVP_VS_LINES,
  parameter int VBP_LINES = DVP_VBP_LINES,
  parameter int VFP_LINES = DVP_VFP_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        underrun
);

  logic       upd, href_next, byte_hi_next, frame_start;
  logic [7:0] data_q, data_d, lo_q, lo_d;
  logic       underrun_q, underrun_d;

  dvp_tx_timing #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .pclk_o        (dvp_pclk),
    .upd_o         (upd),
    .href_next_o   (href_next),
    .byte_hi_next_o(byte_hi_next),
    .frame_start_o (frame_start),
    .href_o        (dvp_href),
    .vsync_o       (dvp_vsync),
    .frame_done_o  (frame_done)
  );

  assign pix_ready = upd & href_next & byte_hi_next;

  // A missing pixel is sent as 0x0000; the raster never stalls.
  always_comb begin
    data_d     = data_q;
    lo_d       = lo_q;
    underrun_d = underrun_q;
    if (upd) begin
      if (!href_next) begin
        data_d = '0;
      end else if (byte_hi_next) begin
        data_d = pix_valid ? pix_data[15:8] : 8'h00;
        lo_d   = pix_valid ? pix_data[7:0]  : 8'h00;
      end else begin
        data_d = lo_q;
      end
    end
    if (frame_start)
      underrun_d = 1'b0;
    else if (pix_ready && !pix_valid)
      underrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      lo_q       <= '0;
      underrun_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      lo_q       <= lo_d;
      underrun_q <= underrun_d;
    end
  end

  assign dvp_data = data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Randomised scoreboard bench for dvp_tx against a frame-position reference model.
module tb_dvp_tx;

  localparam int HA = 4, VA = 2, HB = 4, VS = 1, VBP = 1, VFP = 1;
  localparam int LINE = 2 * HA + HB;
  localparam int FRAME_PCLK = (VS + VBP + VA + VFP) * LINE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, dvp_pclk, dvp_vsync, dvp_href, frame_done, underrun;
  logic [7:0]  dvp_data;

  dvp_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .dvp_pclk(dvp_pclk), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_data(dvp_data), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       ready;
    logic       fdone;
    logic       under;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a single pclk-period index into the frame, plus a busy flag.
  bit          m_pclk, m_busy, m_under;
  int          m_pos;
  logic [15:0] m_pix;
  int          ramp_k, pix_n;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit href_at(input bit b, input int p);
    int ln, col;
    ln  = p / LINE;
    col = p % LINE;
    return b && (ln >= VS + VBP) && (ln < VS + VBP + VA) && (col < 2 * HA);
  endfunction

  task automatic next_pos(input bit b, input int p, input bit en, output bit nb, output int np);
    if (!b || p == FRAME_PCLK - 1) begin
      nb = en;
      np = 0;
    end else begin
      nb = 1'b1;
      np = p + 1;
    end
  endtask

  task automatic model_reset();
    m_pclk = 0; m_busy = 0; m_under = 0; m_pos = 0; m_pix = 16'h0;
  endtask

  task automatic model_cycle();
    exp_t e;
    bit   nb, rdy;
    int   np;
    nb  = 0;
    np  = 0;
    rdy = 0;
    e.pclk  = m_pclk;
    e.vsync = m_busy && (m_pos / LINE) < VS;
    e.href  = href_at(m_busy, m_pos);
    e.data  = !e.href ? 8'h00 : (((m_pos % LINE) % 2 == 0) ? m_pix[15:8] : m_pix[7:0]);
    e.fdone = m_busy && (m_pos == FRAME_PCLK - 1) && m_pclk;
    if (m_pclk) begin
      next_pos(m_busy, m_pos, enable, nb, np);
      rdy = href_at(nb, np) && ((np % LINE) % 2 == 0);
    end
    e.ready = rdy;
    e.under = m_under;
    exp_q.push_back(e);
    if (rdy) begin
      pix_n++;
      if (pix_valid) begin
        m_pix = pix_data;
        ramp_k++;
        $display("pixel %0d: accepted %h", pix_n, pix_data);
      end else begin
        m_pix   = 16'h0000;
        m_under = 1'b1;
        $display("pixel %0d: underrun, sent 0000", pix_n);
      end
    end
    if (m_pclk) begin
      if (nb && np == 0) m_under = 1'b0;
      m_busy = nb;
      m_pos  = np;
    end
    m_pclk = !m_pclk;
  endtask

  task automatic step(input bit en, input int valid_pct, input bit ramp_mode);
    @(posedge clk);
    #1;
    enable    = en;
    pix_valid = ($urandom_range(99) < valid_pct);
    pix_data  = ramp_mode ? {8'(2 * ramp_k + 1), 8'(2 * ramp_k + 2)} : 16'($urandom);
    model_cycle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    enable    = 1'b0;
    pix_valid = 1'b0;
    model_cycle();
  endtask

  // Monitor: one scoreboard entry per clk, sampled on the falling clk edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pclk",       {7'h0, dvp_pclk},   {7'h0, e.pclk});
        chk("vsync",      {7'h0, dvp_vsync},  {7'h0, e.vsync});
        chk("href",       {7'h0, dvp_href},   {7'h0, e.href});
        chk("data",       dvp_data,           e.data);
        chk("pix_ready",  {7'h0, pix_ready},  {7'h0, e.ready});
        chk("frame_done", {7'h0, frame_done}, {7'h0, e.fdone});
        chk("underrun",   {7'h0, underrun},   {7'h0, e.under});
      end
    end
  end

  initial begin
    int  guard;
    bit  hit;
    model_reset();
    ramp_k = 0;
    pix_n  = 0;
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 50; i++) step(1'b0, 100, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 100, 1'b1);
    for (int i = 0; i < 360; i++) step(1'b1, 85, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b1, 90, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b0, 90, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 100, 1'b0);

    hit = 0;
    for (guard = 0; guard < 200 && !hit; guard++) begin
      step(1'b1, 100, 1'b0);
      hit = href_at(m_busy, m_pos);
    end
    if (!hit) begin
      errors++;
      $display("FAIL href_wait: got no href within 200 clk, required href before reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_pclk",      {7'h0, dvp_pclk},   8'h00);
    chk("rst_vsync",     {7'h0, dvp_vsync},  8'h00);
    chk("rst_href",      {7'h0, dvp_href},   8'h00);
    chk("rst_data",      dvp_data,           8'h00);
    chk("rst_pix_ready", {7'h0, pix_ready},  8'h00);
    chk("rst_frame_done",{7'h0, frame_done}, 8'h00);
    chk("rst_underrun",  {7'h0, underrun},   8'h00);
    model_reset();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 100, 1'b0);
    for (int i = 0; i < 150; i++) step(1'b1, 70, 1'b0);
    for (int i = 0; i < 130; i++) step(1'b1, 100, 1'b0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
